// File: rtl/tlul_pkg.sv
// TL-UL channel payloads shared by the arbiter and its neighbours.
package tlul_pkg;

    // Host-to-device: A channel request plus the D channel ready.
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    // Device-to-host: D channel response plus the A channel ready.
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_host_arbiter.sv
// Two-host TL-UL arbiter: round-robin A grant with a hold lock, and an
// in-order FIFO of grant indices that steers D responses back to their host.
module tlul_host_arbiter
    import tlul_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  tl_h2d_t                             tl_h0_i,
    output tl_d2h_t                             tl_h0_o,
    input  tl_h2d_t                             tl_h1_i,
    output tl_d2h_t                             tl_h1_o,
    output tl_h2d_t                             tl_dev_o,
    input  tl_d2h_t                             tl_dev_i,
    output logic [1:0]                          grant_o,
    output logic [$clog2(MaxOutstanding):0]     outstanding_o,
    output logic                                err_unexp_rsp_o
);

    localparam int unsigned PtrW = $clog2(MaxOutstanding);
    localparam int unsigned CntW = PtrW + 1;

    logic            rr_ptr;
    logic            lock;
    logic            lock_host;
    logic            fifo_mem [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            err_q;

    logic            gnt_valid;
    logic            gnt_idx;
    tl_h2d_t         sel_req;
    logic            fifo_full;
    logic            fifo_empty;
    logic            head;
    logic            dev_a_valid;
    logic            dev_d_ready;
    logic            accept;
    logic            pop;

    assign fifo_full  = (count == CntW'(MaxOutstanding));
    assign fifo_empty = (count == '0);
    assign head       = fifo_mem[rd_ptr];

    // Grant selection: a locked host keeps the grant until its request is accepted.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = 1'b0;
        if (lock) begin
            gnt_valid = 1'b1;
            gnt_idx   = lock_host;
        end else if (tl_h0_i.a_valid && tl_h1_i.a_valid) begin
            gnt_valid = 1'b1;
            gnt_idx   = rr_ptr;
        end else if (tl_h0_i.a_valid) begin
            gnt_valid = 1'b1;
            gnt_idx   = 1'b0;
        end else if (tl_h1_i.a_valid) begin
            gnt_valid = 1'b1;
            gnt_idx   = 1'b1;
        end
    end

    assign sel_req     = gnt_idx ? tl_h1_i : tl_h0_i;
    assign dev_a_valid = gnt_valid && sel_req.a_valid && !fifo_full && !rst;
    // An empty FIFO sinks stray responses so the device never stalls on them.
    assign dev_d_ready = fifo_empty ? 1'b1 : (head ? tl_h1_i.d_ready : tl_h0_i.d_ready);
    assign accept      = dev_a_valid && tl_dev_i.a_ready;
    assign pop         = tl_dev_i.d_valid && dev_d_ready && !fifo_empty;

    // A path toward the device: granted host's fields, gated valid.
    always_comb begin
        tl_dev_o         = sel_req;
        tl_dev_o.a_valid = dev_a_valid;
        tl_dev_o.d_ready = dev_d_ready;
    end

    // Response and ready fan-out to the two hosts.
    always_comb begin
        tl_h0_o         = tl_dev_i;
        tl_h1_o         = tl_dev_i;
        tl_h0_o.d_valid = tl_dev_i.d_valid && !fifo_empty && !head && !rst;
        tl_h1_o.d_valid = tl_dev_i.d_valid && !fifo_empty &&  head && !rst;
        tl_h0_o.a_ready = gnt_valid && !gnt_idx && tl_dev_i.a_ready && !fifo_full && !rst;
        tl_h1_o.a_ready = gnt_valid &&  gnt_idx && tl_dev_i.a_ready && !fifo_full && !rst;
    end

    assign grant_o         = (gnt_valid && !rst) ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    assign outstanding_o   = count;
    assign err_unexp_rsp_o = err_q;

    // Round-robin pointer and hold lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= 1'b0;
            lock      <= 1'b0;
            lock_host <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~gnt_idx;
            lock   <= 1'b0;
        end else if (dev_a_valid) begin
            lock      <= 1'b1;
            lock_host <= gnt_idx;
        end
    end

    // Routing FIFO storage; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= gnt_idx;
        end
    end

    // Routing FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky flag for a response that had no matching request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (tl_dev_i.d_valid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tlul_host_arbiter.sv
// Bench for tlul_host_arbiter: vector table, corner sequences, random traffic.
module tb_tlul_host_arbiter;
    import tlul_pkg::*;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    tl_h2d_t    h0_i, h1_i, dev_o;
    tl_d2h_t    h0_o, h1_o, dev_i;
    logic [1:0] grant;
    logic [2:0] outst;
    logic       err;

    int checks   = 0;
    int failures = 0;

    tlul_host_arbiter #(.MaxOutstanding(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .tl_h0_i         (h0_i),
        .tl_h0_o         (h0_o),
        .tl_h1_i         (h1_i),
        .tl_h1_o         (h1_o),
        .tl_dev_o        (dev_o),
        .tl_dev_i        (dev_i),
        .grant_o         (grant),
        .outstanding_o   (outst),
        .err_unexp_rsp_o (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        h0_i = '0;
        h1_i = '0;
        dev_i = '0;
        h0_i.d_ready = 1'b1;
        h1_i.d_ready = 1'b1;
        h0_i.a_address = 32'h100;
        h1_i.a_address = 32'h200;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       v0, v1, rdy;
        logic [1:0] g;
        logic       dv, r0, r1;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl [9];

    typedef struct {
        int         host;
        logic [7:0] src;
    } ent_t;

    // Reference state: queue of (host, source) in issue order, preferred host, held host.
    ent_t       mq [$];
    int         pref;
    int         held;
    logic [7:0] dev_q [$];

    initial begin
        logic [1:0] eg;
        int         g;
        int         v [2];
        int         dr [2];
        logic       exp_dv, exp_full, dpend, acc, popm;
        logic       pend [2];
        logic [7:0] src [2];
        logic [31:0] addr [2];
        logic       rdy;

        rst = 1'b1;
        idle_inputs();
        h0_i.a_valid = 1'b1;
        h1_i.a_valid = 1'b1;
        dev_i.a_ready = 1'b1;
        dev_i.d_valid = 1'b1;
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_outst", 32'(outst), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_dev_valid", 32'(dev_o.a_valid), 32'd0);
        chk("rst_h0_ready", 32'(h0_o.a_ready), 32'd0);
        chk("rst_h1_ready", 32'(h1_o.a_ready), 32'd0);
        chk("rst_h0_dvalid", 32'(h0_o.d_valid), 32'd0);
        do_reset();

        // Cycle-by-cycle table from reset with no D traffic.
        tbl[0] = '{v0:0, v1:0, rdy:1, g:2'b00, dv:0, r0:0, r1:0, cnt:0};
        tbl[1] = '{v0:1, v1:1, rdy:1, g:2'b01, dv:1, r0:1, r1:0, cnt:0};
        tbl[2] = '{v0:1, v1:1, rdy:1, g:2'b10, dv:1, r0:0, r1:1, cnt:1};
        tbl[3] = '{v0:0, v1:1, rdy:0, g:2'b10, dv:1, r0:0, r1:0, cnt:2};
        tbl[4] = '{v0:1, v1:1, rdy:0, g:2'b10, dv:1, r0:0, r1:0, cnt:2};
        tbl[5] = '{v0:1, v1:1, rdy:1, g:2'b10, dv:1, r0:0, r1:1, cnt:2};
        tbl[6] = '{v0:1, v1:1, rdy:1, g:2'b01, dv:1, r0:1, r1:0, cnt:3};
        tbl[7] = '{v0:1, v1:1, rdy:1, g:2'b10, dv:0, r0:0, r1:0, cnt:4};
        tbl[8] = '{v0:1, v1:0, rdy:1, g:2'b01, dv:0, r0:0, r1:0, cnt:4};
        for (int i = 0; i < 9; i++) begin
            h0_i.a_valid  = tbl[i].v0;
            h1_i.a_valid  = tbl[i].v1;
            dev_i.a_ready = tbl[i].rdy;
            #1;
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
            chk($sformatf("tbl%0d_dev_valid", i), 32'(dev_o.a_valid), 32'(tbl[i].dv));
            chk($sformatf("tbl%0d_h0_ready", i), 32'(h0_o.a_ready), 32'(tbl[i].r0));
            chk($sformatf("tbl%0d_h1_ready", i), 32'(h1_o.a_ready), 32'(tbl[i].r1));
            chk($sformatf("tbl%0d_outst", i), 32'(outst), 32'(tbl[i].cnt));
            if (tbl[i].g != 2'b00)
                chk($sformatf("tbl%0d_addr", i), dev_o.a_address,
                    (tbl[i].g == 2'b01) ? 32'h100 : 32'h200);
            @(negedge clk);
        end

        // Full FIFO: a D pop does not unblock A in the same cycle.
        h0_i.a_valid  = 1'b1;
        h1_i.a_valid  = 1'b0;
        dev_i.a_ready = 1'b1;
        dev_i.d_valid = 1'b1;
        #1;
        chk("full_pop_dev_valid", 32'(dev_o.a_valid), 32'd0);
        chk("full_pop_h0_ready", 32'(h0_o.a_ready), 32'd0);
        chk("full_pop_h0_dvalid", 32'(h0_o.d_valid), 32'd1);
        chk("full_pop_h1_dvalid", 32'(h1_o.d_valid), 32'd0);
        chk("full_pop_dev_dready", 32'(dev_o.d_ready), 32'd1);
        @(negedge clk);
        dev_i.d_valid = 1'b0;
        #1;
        chk("after_pop_outst", 32'(outst), 32'd3);
        chk("after_pop_dev_valid", 32'(dev_o.a_valid), 32'd1);
        chk("after_pop_h0_ready", 32'(h0_o.a_ready), 32'd1);
        @(negedge clk);
        // Head is now host 1 (second entry): response must go to h1.
        h0_i.a_valid = 1'b0;
        dev_i.d_valid = 1'b1;
        h1_i.d_ready = 1'b0;
        #1;
        chk("head1_h1_dvalid", 32'(h1_o.d_valid), 32'd1);
        chk("head1_h0_dvalid", 32'(h0_o.d_valid), 32'd0);
        chk("head1_dev_dready", 32'(dev_o.d_ready), 32'd0);
        @(negedge clk);
        chk("head1_stall_outst", 32'(outst), 32'd4);

        // Asynchronous reset mid-operation with requests and responses pending.
        h0_i.a_valid = 1'b1;
        h1_i.a_valid = 1'b1;
        h1_i.d_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outst", 32'(outst), 32'd0);
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_h0_ready", 32'(h0_o.a_ready), 32'd0);
        chk("async_rst_dev_valid", 32'(dev_o.a_valid), 32'd0);
        chk("async_rst_h1_dvalid", 32'(h1_o.d_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dev_i.a_ready = 1'b0;
        #1;
        chk("late_rsp_dev_dready", 32'(dev_o.d_ready), 32'd1);
        chk("late_rsp_h0_dvalid", 32'(h0_o.d_valid), 32'd0);
        chk("late_rsp_h1_dvalid", 32'(h1_o.d_valid), 32'd0);
        chk("post_rst_grant", 32'(grant), 32'b01);
        chk("late_rsp_err_pre", 32'(err), 32'd0);
        @(negedge clk);
        dev_i.d_valid = 1'b0;
        dev_i.a_ready = 1'b1;
        #1;
        chk("late_rsp_err_set", 32'(err), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("err_sticky", 32'(err), 32'd1);
        rst = 1'b1;
        #1;
        chk("err_cleared", 32'(err), 32'd0);
        do_reset();

        // Random traffic against the reference model.
        mq.delete();
        dev_q.delete();
        pref  = 0;
        held  = -1;
        dpend = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int h = 0; h < 2; h++) begin
                if (!pend[h] && ($urandom % 3 == 0)) begin
                    pend[h] = 1'b1;
                    src[h]  = {h[0], 7'($urandom)};
                    addr[h] = $urandom;
                end
                dr[h] = ($urandom % 4 != 0) ? 1 : 0;
            end
            h0_i.a_valid   = pend[0];
            h0_i.a_source  = src[0];
            h0_i.a_address = addr[0];
            h0_i.d_ready   = dr[0][0];
            h1_i.a_valid   = pend[1];
            h1_i.a_source  = src[1];
            h1_i.a_address = addr[1];
            h1_i.d_ready   = dr[1][0];
            rdy = ($urandom % 4 != 0);
            dev_i.a_ready = rdy;
            if (!dpend && dev_q.size() > 0 && ($urandom % 2 == 0)) begin
                dpend = 1'b1;
                dev_i.d_source = dev_q[0];
                dev_i.d_data   = $urandom;
            end
            dev_i.d_valid = dpend;
            #1;

            v[0] = pend[0] ? 1 : 0;
            v[1] = pend[1] ? 1 : 0;
            if (held >= 0) g = held;
            else if (v[0] == 1 && v[1] == 1) g = pref;
            else if (v[0] == 1) g = 0;
            else if (v[1] == 1) g = 1;
            else g = -1;
            exp_full = (mq.size() == N);
            exp_dv   = (g >= 0) && (v[g] == 1) && !exp_full;
            eg = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);

            chk("rnd_grant", 32'(grant), 32'(eg));
            chk("rnd_dev_valid", 32'(dev_o.a_valid), 32'(exp_dv));
            chk("rnd_h0_ready", 32'(h0_o.a_ready), 32'(g == 0 && rdy && !exp_full));
            chk("rnd_h1_ready", 32'(h1_o.a_ready), 32'(g == 1 && rdy && !exp_full));
            chk("rnd_outst", 32'(outst), 32'(mq.size()));
            if (exp_dv) begin
                chk("rnd_a_source", 32'(dev_o.a_source), 32'(src[g]));
                chk("rnd_a_address", dev_o.a_address, addr[g]);
            end
            if (mq.size() > 0) begin
                chk("rnd_h0_dvalid", 32'(h0_o.d_valid), 32'(dpend && mq[0].host == 0));
                chk("rnd_h1_dvalid", 32'(h1_o.d_valid), 32'(dpend && mq[0].host == 1));
                chk("rnd_dev_dready", 32'(dev_o.d_ready), 32'(dr[mq[0].host]));
                if (dpend)
                    chk("rnd_d_source", 32'(dev_i.d_source), 32'(mq[0].src));
            end else begin
                chk("rnd_empty_dready", 32'(dev_o.d_ready), 32'd1);
            end

            // Stimulus bookkeeping from observed handshakes.
            if (h0_i.a_valid && h0_o.a_ready) pend[0] = 1'b0;
            if (h1_i.a_valid && h1_o.a_ready) pend[1] = 1'b0;
            if (dev_i.d_valid && dev_o.d_ready) begin
                dpend = 1'b0;
                if (dev_q.size() > 0) void'(dev_q.pop_front());
            end
            if (dev_o.a_valid && dev_i.a_ready) dev_q.push_back(dev_o.a_source);

            // Reference update for the coming edge.
            acc  = exp_dv && rdy;
            popm = dpend_prev(dev_i.d_valid) && (mq.size() > 0) && (dr[mq[0].host] == 1);
            if (popm) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{host: g, src: src_of(g, h0_i.a_source, h1_i.a_source)});
                pref = 1 - g;
                held = -1;
            end else if (exp_dv) begin
                held = g;
            end
            @(negedge clk);
        end
        chk("rnd_err_clear", 32'(err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic dpend_prev(input logic d_valid);
        return d_valid;
    endfunction

    function automatic logic [7:0] src_of(input int g, input logic [7:0] s0, input logic [7:0] s1);
        return (g == 0) ? s0 : s1;
    endfunction

endmodule
